// File: rtl/sdram_traffic_gen.sv
// SDRAM write-then-read-back traffic generator with miscompare counting and ack timeout.
// Optional macro SDRAM_TRAFFIC_GEN_LFSR_EN selects LFSR data instead of the address-derived pattern.
module sdram_traffic_gen #(
    parameter logic [21:0] BASE_ADDR = 22'h000000,
    parameter int          NUM_WORDS = 256,
    parameter int          TIMEOUT   = 1023
) (
    input  logic        iclk,
    input  logic        ireset_n,
    input  logic        istart,
    output logic        owrite_req,
    output logic [21:0] owrite_address,
    output logic [15:0] owrite_data,
    input  logic        iwrite_ack,
    output logic        oread_req,
    output logic [21:0] oread_address,
    input  logic [15:0] iread_data,
    input  logic        iread_ack,
    output logic        obusy,
    output logic        odone,
    output logic        opass,
    output logic        otimeout,
    output logic [15:0] oerr_count,
    output logic [21:0] ofirst_err_addr
);

    typedef enum logic [2:0] {IDLE, WRITE, WGAP, READ, RGAP, DONE} state_t;

    localparam logic [22:0] LAST_IDX = 23'(NUM_WORDS);
    localparam logic [31:0] WAIT_LIM = 32'(TIMEOUT);
    localparam logic [15:0] DATA_XOR = 16'h5A5A;

    state_t      state;
    logic [22:0] idx;
    logic [31:0] wait_cnt;
    logic [21:0] next_addr;
    logic [15:0] first_data;
    logic [15:0] gap_data;
    logic [15:0] exp_data;
    logic        start_ok;
    logic        expired;

    assign next_addr = BASE_ADDR + idx[21:0];
    assign start_ok  = istart && (state == IDLE || state == DONE);
    assign expired   = (wait_cnt + 32'd1) >= WAIT_LIM;

`ifdef SDRAM_TRAFFIC_GEN_LFSR_EN
    localparam logic [15:0] SEED = 16'hACE1;
    logic [15:0] lfsr;

    // Steps once per accepted ack; reseeded when either phase begins.
    always_ff @(posedge iclk) begin
        if (!ireset_n) begin
            lfsr <= SEED;
        end else if (start_ok || (state == WGAP && idx == LAST_IDX)) begin
            lfsr <= SEED;
        end else if ((state == WRITE && iwrite_ack) || (state == READ && iread_ack)) begin
            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        end
    end

    assign first_data = SEED;
    assign gap_data   = lfsr;
    assign exp_data   = lfsr;
`else
    assign first_data = BASE_ADDR[15:0] ^ DATA_XOR;
    assign gap_data   = next_addr[15:0] ^ DATA_XOR;
    assign exp_data   = oread_address[15:0] ^ DATA_XOR;
`endif

    always_ff @(posedge iclk) begin
        if (!ireset_n) begin
            state           <= IDLE;
            idx             <= '0;
            wait_cnt        <= '0;
            owrite_req      <= 1'b0;
            owrite_address  <= '0;
            owrite_data     <= '0;
            oread_req       <= 1'b0;
            oread_address   <= '0;
            obusy           <= 1'b0;
            odone           <= 1'b0;
            opass           <= 1'b0;
            otimeout        <= 1'b0;
            oerr_count      <= '0;
            ofirst_err_addr <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (istart) begin
                        idx             <= '0;
                        wait_cnt        <= '0;
                        odone           <= 1'b0;
                        opass           <= 1'b0;
                        otimeout        <= 1'b0;
                        oerr_count      <= '0;
                        ofirst_err_addr <= '0;
                        if (NUM_WORDS == 0) begin
                            state <= DONE;
                            odone <= 1'b1;
                            opass <= 1'b1;
                        end else begin
                            state          <= WRITE;
                            obusy          <= 1'b1;
                            owrite_req     <= 1'b1;
                            owrite_address <= BASE_ADDR;
                            owrite_data    <= first_data;
                        end
                    end
                end
                WRITE: begin
                    if (iwrite_ack) begin
                        owrite_req <= 1'b0;
                        idx        <= idx + 23'd1;
                        state      <= WGAP;
                    end else if (expired) begin
                        owrite_req <= 1'b0;
                        otimeout   <= 1'b1;
                        obusy      <= 1'b0;
                        odone      <= 1'b1;
                        opass      <= 1'b0;
                        state      <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                WGAP: begin
                    wait_cnt <= '0;
                    if (idx == LAST_IDX) begin
                        idx           <= '0;
                        state         <= READ;
                        oread_req     <= 1'b1;
                        oread_address <= BASE_ADDR;
                    end else begin
                        state          <= WRITE;
                        owrite_req     <= 1'b1;
                        owrite_address <= next_addr;
                        owrite_data    <= gap_data;
                    end
                end
                READ: begin
                    if (iread_ack) begin
                        oread_req <= 1'b0;
                        idx       <= idx + 23'd1;
                        state     <= RGAP;
                        // A saturated count is never zero, so zero reliably means "no earlier miscompare".
                        if (iread_data != exp_data) begin
                            if (oerr_count != 16'hFFFF) oerr_count <= oerr_count + 16'd1;
                            if (oerr_count == 16'd0) ofirst_err_addr <= oread_address;
                        end
                    end else if (expired) begin
                        oread_req <= 1'b0;
                        otimeout  <= 1'b1;
                        obusy     <= 1'b0;
                        odone     <= 1'b1;
                        opass     <= 1'b0;
                        state     <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                RGAP: begin
                    wait_cnt <= '0;
                    if (idx == LAST_IDX) begin
                        state <= DONE;
                        obusy <= 1'b0;
                        odone <= 1'b1;
                        opass <= (oerr_count == 16'd0) && !otimeout;
                    end else begin
                        state         <= READ;
                        oread_req     <= 1'b1;
                        oread_address <= next_addr;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_traffic_gen.sv
// Self-checking bench for sdram_traffic_gen: table-driven and randomized runs against a
// transaction-level model, plus timeout, mid-run reset and empty-region corner cases.
`timescale 1ns/1ps
module tb_sdram_traffic_gen;

    localparam logic [21:0] BASE_A = 22'h000000;
    localparam logic [21:0] BASE_B = 22'h3FFFFE;
    localparam int          NW     = 4;
    localparam int          TO     = 15;
`ifdef SDRAM_TRAFFIC_GEN_LFSR_EN
    localparam logic [15:0] FIRST_DATA = 16'hACE1;
`else
    localparam logic [15:0] FIRST_DATA = 16'h5A5A;
`endif

    typedef struct {
        int              lat;
        logic [3:0][15:0] mask;
        int              exp_err;
        logic [21:0]     exp_first_a;
        logic [21:0]     exp_first_b;
        logic            exp_pass;
    } run_vec_t;

    logic        clk = 1'b0;
    logic        ireset_n, istart, iwrite_ack, iread_ack;
    logic [15:0] rd_data_a, rd_data_b;

    logic        w_req_a, r_req_a, busy_a, done_a, pass_a, tmo_a;
    logic [21:0] w_addr_a, r_addr_a, ferr_a;
    logic [15:0] w_data_a, err_a;
    logic        w_req_b, r_req_b, busy_b, done_b, pass_b, tmo_b;
    logic [21:0] w_addr_b, r_addr_b, ferr_b;
    logic [15:0] w_data_b, err_b;
    logic        w_req_c, r_req_c, busy_c, done_c, pass_c, tmo_c;
    logic [21:0] w_addr_c, r_addr_c, ferr_c;
    logic [15:0] w_data_c, err_c;
    logic        any_out;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    assign any_out = |{w_req_a, w_addr_a, w_data_a, r_req_a, r_addr_a, busy_a, done_a, pass_a, tmo_a, err_a, ferr_a,
                       w_req_b, w_addr_b, w_data_b, r_req_b, r_addr_b, busy_b, done_b, pass_b, tmo_b, err_b, ferr_b,
                       w_req_c, w_addr_c, w_data_c, r_req_c, r_addr_c, busy_c, done_c, pass_c, tmo_c, err_c, ferr_c};

    sdram_traffic_gen #(.BASE_ADDR(BASE_A), .NUM_WORDS(NW), .TIMEOUT(TO)) dut_a (
        .iclk(clk), .ireset_n(ireset_n), .istart(istart),
        .owrite_req(w_req_a), .owrite_address(w_addr_a), .owrite_data(w_data_a), .iwrite_ack(iwrite_ack),
        .oread_req(r_req_a), .oread_address(r_addr_a), .iread_data(rd_data_a), .iread_ack(iread_ack),
        .obusy(busy_a), .odone(done_a), .opass(pass_a), .otimeout(tmo_a),
        .oerr_count(err_a), .ofirst_err_addr(ferr_a));

    sdram_traffic_gen #(.BASE_ADDR(BASE_B), .NUM_WORDS(NW), .TIMEOUT(TO)) dut_b (
        .iclk(clk), .ireset_n(ireset_n), .istart(istart),
        .owrite_req(w_req_b), .owrite_address(w_addr_b), .owrite_data(w_data_b), .iwrite_ack(iwrite_ack),
        .oread_req(r_req_b), .oread_address(r_addr_b), .iread_data(rd_data_b), .iread_ack(iread_ack),
        .obusy(busy_b), .odone(done_b), .opass(pass_b), .otimeout(tmo_b),
        .oerr_count(err_b), .ofirst_err_addr(ferr_b));

    sdram_traffic_gen #(.BASE_ADDR(BASE_A), .NUM_WORDS(0), .TIMEOUT(TO)) dut_c (
        .iclk(clk), .ireset_n(ireset_n), .istart(istart),
        .owrite_req(w_req_c), .owrite_address(w_addr_c), .owrite_data(w_data_c), .iwrite_ack(iwrite_ack),
        .oread_req(r_req_c), .oread_address(r_addr_c), .iread_data(rd_data_a), .iread_ack(iread_ack),
        .obusy(busy_c), .odone(done_c), .opass(pass_c), .otimeout(tmo_c),
        .oerr_count(err_c), .ofirst_err_addr(ferr_c));

    // Expected data of the k-th word of a phase, straight from the pattern definition.
    function automatic logic [15:0] refData(input logic [21:0] base, input int k);
`ifdef SDRAM_TRAFFIC_GEN_LFSR_EN
        logic [15:0] v;
        v = 16'hACE1;
        for (int i = 0; i < k; i++) v = {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
        return v;
`else
        logic [21:0] a;
        a = base + 22'(k);
        return a[15:0] ^ 16'h5A5A;
`endif
    endfunction

    function automatic run_vec_t mkVec(input int lat, input logic [15:0] m3, input logic [15:0] m2,
                                       input logic [15:0] m1, input logic [15:0] m0, input int err,
                                       input logic [21:0] fa, input logic [21:0] fb, input logic pass);
        run_vec_t v;
        v.lat = lat;
        v.mask = {m3, m2, m1, m0};
        v.exp_err = err;
        v.exp_first_a = fa;
        v.exp_first_b = fb;
        v.exp_pass = pass;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected)
            $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
        else
            passes++;
    endtask

    task automatic startPulse();
        @(negedge clk);
        istart = 1'b1;
        @(negedge clk);
        istart = 1'b0;
    endtask

    // One full run with the controller model; abort_read >= 0 pulses reset when that read begins.
    task automatic applyStimulus(input run_vec_t v, input bit rnd, input int abort_read);
        int          wr_idx = 0, rd_idx = 0, age = 0, lat = 1, low_cnt = 0, proto = 0;
        bit          in_req = 0, acked_once = 0, finished = 0, aborted = 0;
        logic [21:0] exp_addr, cur_addr;
        logic [15:0] mask;
        cur_addr = '0;
        startPulse();
        for (int cyc = 0; cyc < 300; cyc++) begin
            iwrite_ack = 1'b0;
            iread_ack  = 1'b0;
            istart     = 1'b0;
            if (w_req_a !== w_req_b || r_req_a !== r_req_b || (w_req_a && r_req_a)) proto++;
            if (w_req_c || r_req_c) proto++;
            if (in_req && (w_req_a || r_req_a) && (w_req_a ? w_addr_a : r_addr_a) != cur_addr) proto++;
            if (r_req_a && !in_req && rd_idx == abort_read) begin
                ireset_n = 1'b0;
                @(negedge clk);
                ireset_n = 1'b1;
                checkOutput("reset_mid_run_outputs", 32'(any_out), 32'd0);
                aborted = 1;
                break;
            end
            if (w_req_a || r_req_a) begin
                if (!in_req) begin
                    in_req = 1;
                    age = 0;
                    lat = rnd ? int'($urandom_range(1, 12)) : v.lat;
                    if (acked_once && low_cnt != 1) proto++;
                    low_cnt = 0;
                    cur_addr = w_req_a ? w_addr_a : r_addr_a;
                    if (w_req_a) begin
                        if (wr_idx >= NW) proto++;
                        exp_addr = BASE_A + 22'(wr_idx);
                        checkOutput("wr_addr_a", 32'(w_addr_a), 32'(exp_addr));
                        checkOutput("wr_data_a", 32'(w_data_a), 32'(refData(BASE_A, wr_idx)));
                        exp_addr = BASE_B + 22'(wr_idx);
                        checkOutput("wr_addr_b", 32'(w_addr_b), 32'(exp_addr));
                        checkOutput("wr_data_b", 32'(w_data_b), 32'(refData(BASE_B, wr_idx)));
                        if (wr_idx == 0) checkOutput("first_wr_data", 32'(w_data_a), 32'(FIRST_DATA));
                    end else begin
                        if (wr_idx != NW || rd_idx >= NW) proto++;
                        exp_addr = BASE_A + 22'(rd_idx);
                        checkOutput("rd_addr_a", 32'(r_addr_a), 32'(exp_addr));
                        exp_addr = BASE_B + 22'(rd_idx);
                        checkOutput("rd_addr_b", 32'(r_addr_b), 32'(exp_addr));
                    end
                end
                if (age == lat - 1) begin
                    if (w_req_a) begin
                        iwrite_ack = 1'b1;
                        wr_idx++;
                    end else begin
                        mask = (rd_idx < NW) ? v.mask[rd_idx] : 16'h0;
                        rd_data_a = refData(BASE_A, rd_idx) ^ mask;
                        rd_data_b = refData(BASE_B, rd_idx) ^ mask;
                        iread_ack = 1'b1;
                        rd_idx++;
                    end
                    in_req = 0;
                    acked_once = 1;
                end else if (rnd && $urandom_range(0, 4) == 0) begin
                    if (w_req_a) begin
                        iread_ack = 1'b1;
                        rd_data_a = 16'($urandom);
                        rd_data_b = 16'($urandom);
                    end else begin
                        iwrite_ack = 1'b1;
                    end
                end
                age++;
            end else begin
                if (in_req) begin
                    proto++;
                    in_req = 0;
                end
                low_cnt++;
                if (rnd && busy_a && $urandom_range(0, 3) == 0) begin
                    if ($urandom_range(0, 1) == 0) begin
                        iwrite_ack = 1'b1;
                    end else begin
                        iread_ack = 1'b1;
                        rd_data_a = 16'($urandom);
                        rd_data_b = 16'($urandom);
                    end
                end
            end
            if (rnd && busy_a && $urandom_range(0, 15) == 0) istart = 1'b1;
            if (done_a) begin
                finished = 1;
                break;
            end
            @(negedge clk);
        end
        iwrite_ack = 1'b0;
        iread_ack  = 1'b0;
        istart     = 1'b0;
        if (aborted) begin
            repeat (5) @(negedge clk);
            checkOutput("idle_after_reset", 32'(w_req_a | r_req_a | busy_a | done_a | w_req_b | r_req_b), 32'd0);
        end else begin
            checkOutput("run_finished", 32'(finished), 32'd1);
            checkOutput("protocol_violations", proto, 0);
            checkOutput("write_count", wr_idx, NW);
            checkOutput("read_count", rd_idx, NW);
            checkOutput("err_count_a", 32'(err_a), v.exp_err);
            checkOutput("err_count_b", 32'(err_b), v.exp_err);
            checkOutput("first_err_a", 32'(ferr_a), 32'(v.exp_first_a));
            checkOutput("first_err_b", 32'(ferr_b), 32'(v.exp_first_b));
            checkOutput("pass_a", 32'(pass_a), 32'(v.exp_pass));
            checkOutput("pass_b", 32'(pass_b), 32'(v.exp_pass));
            checkOutput("done_busy_timeout_a", 32'({done_a, busy_a, tmo_a}), 32'b100);
        end
    endtask

    initial begin
        run_vec_t vecs[5];
        run_vec_t rv;
        int       hi;

        vecs[0] = mkVec(5,  16'h0,    16'h0,    16'h0,    16'h0,    0, 22'h0, 22'h0,      1'b1);
        vecs[1] = mkVec(5,  16'h0,    16'h0001, 16'h0,    16'h0,    1, 22'h2, 22'h0,      1'b0);
        vecs[2] = mkVec(1,  16'hFFFF, 16'h0,    16'h0,    16'h8000, 2, 22'h0, 22'h3FFFFE, 1'b0);
        vecs[3] = mkVec(2,  16'h0001, 16'h0,    16'h0100, 16'h0,    2, 22'h1, 22'h3FFFFF, 1'b0);
        vecs[4] = mkVec(12, 16'h0,    16'h0,    16'h0,    16'h0,    0, 22'h0, 22'h0,      1'b1);

        ireset_n = 1'b0;
        istart = 1'b0;
        iwrite_ack = 1'b0;
        iread_ack = 1'b0;
        rd_data_a = '0;
        rd_data_b = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs", 32'(any_out), 32'd0);
        ireset_n = 1'b1;

        for (int i = 0; i < 5; i++) applyStimulus(vecs[i], 1'b0, -1);

        checkOutput("empty_region_done_pass", 32'({done_c, pass_c, busy_c, tmo_c}), 32'b1100);
        checkOutput("empty_region_err", 32'(err_c), 32'd0);

        // First write never acknowledged: request must stay up exactly TIMEOUT cycles.
        startPulse();
        hi = 0;
        for (int c = 0; c < 40; c++) begin
            if (w_req_a) hi++;
            @(negedge clk);
        end
        checkOutput("timeout_req_cycles", hi, TO);
        checkOutput("timeout_flags_a", 32'({tmo_a, done_a, pass_a, busy_a, r_req_a}), 32'b11000);
        checkOutput("timeout_flag_b", 32'(tmo_b), 32'd1);

        applyStimulus(vecs[0], 1'b0, 1);
        applyStimulus(vecs[0], 1'b0, -1);

        for (int r = 0; r < 8; r++) begin
            rv.lat = 0;
            rv.exp_err = 0;
            rv.exp_first_a = '0;
            rv.exp_first_b = '0;
            for (int k = 0; k < NW; k++) begin
                rv.mask[k] = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'h0;
                if (rv.mask[k] != 16'h0) begin
                    if (rv.exp_err == 0) begin
                        rv.exp_first_a = BASE_A + 22'(k);
                        rv.exp_first_b = BASE_B + 22'(k);
                    end
                    rv.exp_err++;
                end
            end
            rv.exp_pass = (rv.exp_err == 0);
            applyStimulus(rv, 1'b1, -1);
        end

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/sdram_traffic_gen.md
SDRAM_TRAFFIC_GEN -- requirements
Module: sdram_traffic_gen

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 22'h000000, meaning the first word address of the test region.
REQ-002 SHALL have parameter NUM_WORDS, default 256, meaning the number of words written and then read back (range 0..2^22).
REQ-003 SHALL have parameter TIMEOUT, default 1023, meaning the maximum number of cycles to wait for an ack.
REQ-004 iclk  in  1  single clock; all logic on its rising edge.
REQ-005 ireset_n  in  1  reset; synchronous, active-low.
REQ-006 istart  in  1  single-cycle pulse that starts a test run.
REQ-007 owrite_req  out  1  write request to the SDRAM controller.
REQ-008 owrite_address  out  22  write word address {bank,row,col[9:3]}.
REQ-009 owrite_data  out  16  write data.
REQ-010 iwrite_ack  in  1  one-cycle write-complete pulse from the controller.
REQ-011 oread_req  out  1  read request to the SDRAM controller.
REQ-012 oread_address  out  22  read word address.
REQ-013 iread_data  in  16  read data; valid only in the cycle where iread_ack=1.
REQ-014 iread_ack  in  1  one-cycle read-complete pulse from the controller.
REQ-015 obusy  out  1  test run in progress.
REQ-016 odone  out  1  run finished; held until the next start or reset.
REQ-017 opass  out  1  qualified by odone: 1 when error count is 0 and no timeout occurred.
REQ-018 otimeout  out  1  an ack did not arrive within TIMEOUT cycles.
REQ-019 oerr_count  out  16  number of read miscompares; saturates at 16'hFFFF.
REQ-020 ofirst_err_addr  out  22  address of the first miscompare; 0 when there is none.

Function
REQ-021 SHALL implement the FSM IDLE -> WRITE -> WGAP -> ... -> READ -> RGAP -> ... -> DONE; istart in IDLE or DONE SHALL clear the results, set index=0 and enter WRITE (or DONE with opass=1 if NUM_WORDS=0).
REQ-022 SHALL ignore istart while obusy=1.
REQ-023 owrite_req/oread_req SHALL be registered, SHALL rise on entry to WRITE/READ, and SHALL hold address and data stable until the ack.
REQ-024 SHALL clear the request at the clock edge that samples ack=1, so the request is low in the cycle after ack; the GAP state SHALL last exactly 1 cycle before the next request.
REQ-025 Address SHALL be (BASE_ADDR + index) mod 2^22, so the address wraps past 22'h3FFFFF.
REQ-026 On a write ack in WRITE, SHALL increment index; after NUM_WORDS writes, SHALL reset index and the pattern generator and go to READ.
REQ-027 On a read ack, SHALL compare iread_data with the expected pattern for that index in the same cycle; on mismatch SHALL increment oerr_count (saturating) and, if it is the first mismatch, latch ofirst_err_addr.
REQ-028 After NUM_WORDS reads, SHALL enter DONE: obusy=0, odone=1, opass=(oerr_count==0 && !otimeout).
REQ-029 A wait counter SHALL reset on each request rise; if it reaches TIMEOUT with no ack, SHALL drop the request, set otimeout=1 and enter DONE with opass=0.
REQ-030 An ack arriving while no request is outstanding SHALL be ignored.
REQ-031 SHALL never assert owrite_req and oread_req in the same cycle.

Reset
REQ-032 While ireset_n=0 at a clock edge, SHALL set FSM=IDLE and all outputs to 0, including requests, address and data, and SHALL clear the pattern generator to its seed.
REQ-033 Reset mid-run SHALL abort the run with no further requests; recovery SHALL require a new istart.

Configuration
REQ-034 Macro SDRAM_TRAFFIC_GEN_LFSR_EN: when defined, data SHALL come from a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1) that advances once per ack and is reseeded at the start of each phase.
REQ-035 When the macro is not defined, data SHALL be address[15:0] XOR 16'h5A5A, and no LFSR register SHALL exist.

Verification
REQ-036 NUM_WORDS=4, BASE_ADDR=0, controller model acks 5 cycles after each request, perfect memory -> 4 writes then 4 reads to addresses 0..3; result odone=1, opass=1, oerr_count=0.
REQ-037 Same setup, model corrupts the read at address 2 (bit0 flipped) -> oerr_count=1, ofirst_err_addr=2, opass=0.
REQ-038 BASE_ADDR=22'h3FFFFE, NUM_WORDS=4 -> addresses 3FFFFE, 3FFFFF, 000000, 000001 in order.
REQ-039 TIMEOUT=15, model never acks the first write -> owrite_req drops after 15 cycles; otimeout=1, odone=1, opass=0.
REQ-040 ireset_n=0 for 1 cycle during the 2nd read, then istart -> all outputs 0 after reset; a fresh run passes; istart pulses during the run are ignored.
REQ-041 Run with the macro both defined and undefined -> the first write data is 16'hACE1 (defined) or 16'h5A5A at address 0 (undefined).
